inta_sequencer: RTL and testbench
=================================

// Module: inta_sequencer
// PURPOSE
// - CPU-side interrupt acknowledge sequencer. Sits directly downstream of PIC_TopModule.
// - Consumes the PIC's INT output and drives the PIC's active-low INTA input with an 8086-style two-pulse cycle.
// - Captures the vector byte that the PIC drives on sys_DataLine during the second pulse.
// - Presents the vector to the CPU core through a valid/ack handshake.
// PARAMETERS
// - INTA_LOW_CYCLES  2  clocks INTA is held low per pulse; legal range 1..15
// - INTA_GAP_CYCLES  2  clocks INTA is held high between the two pulses; legal range 1..15
// PORTS
// - clk          in   1  single system clock; all state changes on the rising edge
// - rst_n        in   1  asynchronous reset, active-low
// - INT          in   1  interrupt request from PIC, active-high
// - int_en       in   1  CPU interrupt-enable flag (IF)
// - data_in      in   8  read side of sys_DataLine
// - INTA         out  1  acknowledge to PIC, active-low, idle high
// - vector       out  8  captured interrupt vector
// - vector_valid out  1  vector holds a captured value not yet taken by the CPU
// - vector_ack   in   1  CPU takes the vector
// - spurious     out  1  INT was gone at the end of pulse 1; qualifies vector
// - busy         out  1  high in every state except IDLE
// BEHAVIOUR
// - Reset values (asynchronous, immediate, also mid-sequence): INTA=1, vector=8'h00, vector_valid=0, spurious=0, busy=0, state=IDLE, counter=0.
// - Reset mid-pulse releases INTA high at once; no vector is produced.
// - FSM states: IDLE -> P1 -> GAP -> P2 -> HOLD -> IDLE.
// - IDLE: the sequence starts on the edge where INT & int_en = 1; state becomes P1 and counter loads.
// - P1: INTA=0 for exactly INTA_LOW_CYCLES clocks.
//   - Register int_seen = INT on the last P1 cycle.
//   - Then go to GAP.
// - GAP: INTA=1 for exactly INTA_GAP_CYCLES clocks, then go to P2.
// - P2: INTA=0 for exactly INTA_LOW_CYCLES clocks.
//   - On the edge that ends the last P2 cycle: vector<=data_in, spurious<=~int_seen, vector_valid<=1.
//   - Then go to HOLD.
// - HOLD: INTA=1. vector, spurious and vector_valid stay stable until vector_ack=1.
//   - On that edge vector_valid<=0 and state becomes IDLE.
//   - vector keeps its last value.
// - INTA is a registered output, glitch-free, decoded from the next state.
// - Latency with defaults, INT sampled at edge 0:
//   - INTA low for cycles 1-2, high for 3-4, low for 5-6.
//   - vector_valid=1 from cycle 7.
// - Once P1 is entered the full two-pulse sequence always completes.
//   - INT or int_en dropping after that point is ignored, except for the spurious capture.
// - In HOLD, INT is not sampled: no new sequence starts until the vector is acked.
//   - INT still high on return to IDLE starts a new sequence on the next edge.
// - vector_ack outside HOLD is ignored.
// - vector_ack asserted on the same edge that enters HOLD is not seen; the ack must come while vector_valid=1.
// - Counter is 4 bits and counts down.
//   - A pulse or gap ends when counter==0; the counter reloads on every state change.
//   - No wrap-around within a state.
// CONFIGURATION
// - INTA_SEQ_SYNC_EN defined: INT and int_en pass through a 2-flop synchronizer (reset 0) before IDLE sampling.
//   - Start latency grows by 2 clocks.
//   - int_seen uses the synchronized INT.
// - INTA_SEQ_SYNC_EN undefined: INT and int_en are sampled directly; the caller guarantees they are synchronous to clk.
// TESTING
// - Reset, no INT -> INTA=1, vector_valid=0, busy=0 for 20 cycles.
// - INT=1, int_en=1, PIC model drives data_in=8'h4A during P2 (defaults) -> INTA low cycles 1-2 and 5-6; vector=8'h4A, vector_valid=1 at cycle 7, spurious=0; ack at cycle 9 -> vector_valid=0 at cycle 10.
// - INT=1, int_en=0 for 10 cycles -> INTA stays 1; raise int_en -> sequence starts on the next edge.
// - INT pulses high one cycle, then drops; data_in=8'h47 -> sequence completes, vector=8'h47, spurious=1.
// - Hold vector_ack=0 for 30 cycles with INT held high -> exactly two INTA pulses; ack -> a new P1 starts 2 edges later.
// - Drive rst_n low during GAP and during P2 -> INTA=1 and busy=0 immediately (asynchronous); no vector_valid after release.
// - Parameters (LOW=1, GAP=3) -> pulse widths 1/3/1, vector_valid at cycle 6.
// - With INTA_SEQ_SYNC_EN defined -> vector_valid at cycle 9 under defaults.

Source files
------------

// File: rtl/inta_sequencer.sv
// 8086-style two-pulse INTA sequencer: INT -> INTA low/high/low -> vector capture -> valid/ack to CPU.
// Latency (defaults): vector_valid 7 clocks after INT&int_en sampled; INTA_SEQ_SYNC_EN adds a 2-flop input synchronizer (+2 clocks).
module inta_sequencer #(
    parameter int INTA_LOW_CYCLES = 2,
    parameter int INTA_GAP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       INT,
    input  logic       int_en,
    input  logic [7:0] data_in,
    output logic       INTA,
    output logic [7:0] vector,
    output logic       vector_valid,
    input  logic       vector_ack,
    output logic       spurious,
    output logic       busy
);

    typedef enum logic [2:0] {IDLE, P1, GAP, P2, HOLD} state_t;

    localparam logic [3:0] LOW_LOAD = 4'(INTA_LOW_CYCLES - 1);
    localparam logic [3:0] GAP_LOAD = 4'(INTA_GAP_CYCLES - 1);

    state_t     state;
    logic [3:0] counter;
    logic       int_seen;
    logic       int_s;
    logic       en_s;

`ifdef INTA_SEQ_SYNC_EN
    logic [1:0] int_sync;
    logic [1:0] en_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_sync <= 2'b00;
            en_sync  <= 2'b00;
        end else begin
            int_sync <= {int_sync[0], INT};
            en_sync  <= {en_sync[0], int_en};
        end
    end

    assign int_s = int_sync[1];
    assign en_s  = en_sync[1];
`else
    assign int_s = INT;
    assign en_s  = int_en;
`endif

    // INTA and busy are set alongside each state transition, so they track the next state glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            counter      <= 4'd0;
            int_seen     <= 1'b0;
            INTA         <= 1'b1;
            vector       <= 8'h00;
            vector_valid <= 1'b0;
            spurious     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (int_s && en_s) begin
                        state   <= P1;
                        counter <= LOW_LOAD;
                        INTA    <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                P1: begin
                    if (counter == 4'd0) begin
                        int_seen <= int_s;
                        state    <= GAP;
                        counter  <= GAP_LOAD;
                        INTA     <= 1'b1;
                    end else begin
                        counter <= counter - 4'd1;
                    end
                end
                GAP: begin
                    if (counter == 4'd0) begin
                        state   <= P2;
                        counter <= LOW_LOAD;
                        INTA    <= 1'b0;
                    end else begin
                        counter <= counter - 4'd1;
                    end
                end
                P2: begin
                    if (counter == 4'd0) begin
                        state        <= HOLD;
                        counter      <= 4'd0;
                        INTA         <= 1'b1;
                        vector       <= data_in;
                        spurious     <= ~int_seen;
                        vector_valid <= 1'b1;
                    end else begin
                        counter <= counter - 4'd1;
                    end
                end
                HOLD: begin
                    // INT is deliberately ignored here until the CPU has taken the vector.
                    if (vector_ack) begin
                        state        <= IDLE;
                        counter      <= 4'd0;
                        vector_valid <= 1'b0;
                        busy         <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    counter <= 4'd0;
                    INTA    <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inta_sequencer.sv
// Directed bench for inta_sequencer: default-parameter instance plus a LOW=1/GAP=3 instance.
module tb_inta_sequencer;

    logic       clk;
    logic       rst_n;
    logic       int_i, en_i, ack_i;
    logic       int2, en2, ack2;
    logic [7:0] data_in;
    logic       inta, valid, sp, busy;
    logic [7:0] vec;
    logic       inta2, valid2, sp2, busy2;
    logic [7:0] vec2;

    int total  = 0;
    int passed = 0;

    inta_sequencer dut (
        .clk(clk), .rst_n(rst_n), .INT(int_i), .int_en(en_i), .data_in(data_in),
        .INTA(inta), .vector(vec), .vector_valid(valid), .vector_ack(ack_i),
        .spurious(sp), .busy(busy)
    );

    inta_sequencer #(.INTA_LOW_CYCLES(1), .INTA_GAP_CYCLES(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .INT(int2), .int_en(en2), .data_in(data_in),
        .INTA(inta2), .vector(vec2), .vector_valid(valid2), .vector_ack(ack2),
        .spurious(sp2), .busy(busy2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        int_v;
        logic        en_v;
        logic [7:0]  dat;
        logic        ack;
        logic [11:0] exp;
    } vec_t;

    function automatic vec_t mk(logic i, logic e, logic [7:0] d, logic a,
                                logic x_inta, logic x_busy, logic x_valid, logic x_sp, logic [7:0] x_vec);
        vec_t r;
        r.int_v = i; r.en_v = e; r.dat = d; r.ack = a;
        r.exp = {x_inta, x_busy, x_valid, x_sp, x_vec};
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] obs();
        return {inta, busy, valid, sp, vec};
    endfunction

    // Bounded wait for vector_valid on the default instance, then ack it.
    task automatic finish_seq();
        logic found;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (valid) found = 1'b1;
            else tick();
        end
        check("wait_valid", {31'd0, found}, 32'd1);
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        check("ack_clears_valid", {31'd0, valid}, 32'd0);
    endtask

    vec_t tbl[12];

    initial begin
        int pulses;
        logic prev, seen;
        logic [7:0] e2_inta, e2_valid;

        rst_n = 1'b0; int_i = 0; en_i = 0; ack_i = 0; int2 = 0; en2 = 0; ack2 = 0; data_in = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {20'd0, obs()}, {20'd0, 12'b1000_0000_0000});
        rst_n = 1'b1;

        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (!inta || valid || busy) seen = 1'b1;
            tick();
        end
        check("idle_20", {31'd0, seen}, 32'd0);

        // Main sequence; ack during GAP and on the HOLD-entry edge must be ignored.
        tbl[0]  = mk(1, 1, 8'hFF, 0, 1, 0, 0, 0, 8'h00);
        tbl[1]  = mk(1, 1, 8'hFF, 0, 0, 1, 0, 0, 8'h00);
        tbl[2]  = mk(1, 1, 8'hFF, 0, 0, 1, 0, 0, 8'h00);
        tbl[3]  = mk(0, 1, 8'hFF, 1, 1, 1, 0, 0, 8'h00);
        tbl[4]  = mk(0, 1, 8'hFF, 0, 1, 1, 0, 0, 8'h00);
        tbl[5]  = mk(0, 1, 8'h4A, 0, 0, 1, 0, 0, 8'h00);
        tbl[6]  = mk(0, 1, 8'h4A, 1, 0, 1, 0, 0, 8'h00);
        tbl[7]  = mk(0, 1, 8'hFF, 0, 1, 1, 1, 0, 8'h4A);
        tbl[8]  = mk(0, 1, 8'hFF, 0, 1, 1, 1, 0, 8'h4A);
        tbl[9]  = mk(0, 1, 8'hFF, 1, 1, 1, 1, 0, 8'h4A);
        tbl[10] = mk(0, 1, 8'hFF, 0, 1, 0, 0, 0, 8'h4A);
        tbl[11] = mk(0, 1, 8'hFF, 0, 1, 0, 0, 0, 8'h4A);
        for (int i = 0; i < 12; i++) begin
            check($sformatf("main_c%0d", i), {20'd0, obs()}, {20'd0, tbl[i].exp});
            int_i = tbl[i].int_v; en_i = tbl[i].en_v; data_in = tbl[i].dat; ack_i = tbl[i].ack;
            tick();
        end
        ack_i = 0; data_in = 8'hFF;

        // int_en gating
        int_i = 1; en_i = 0;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (!inta || busy) seen = 1'b1;
        end
        check("en_low_blocks", {31'd0, seen}, 32'd0);
        en_i = 1;
        tick();
        check("en_rise_starts", {30'd0, inta, busy}, 32'b01);
        int_i = 0;
        finish_seq();

        // Spurious: INT gone by end of pulse 1
        data_in = 8'h47;
        int_i = 1; en_i = 1;
        tick();
        int_i = 0;
        repeat (5) tick();
        check("spur_c6_not_valid", {31'd0, valid}, 32'd0);
        tick();
        check("spur_c7", {29'd0, valid, sp, busy}, 32'b111);
        check("spur_vector", {24'd0, vec}, 32'h47);
        finish_seq();

        // HOLD blocks new sequences while INT stays high
        data_in = 8'h33; int_i = 1; en_i = 1;
        pulses = 0; prev = inta;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (prev && !inta) pulses++;
            prev = inta;
        end
        check("hold_pulses", pulses, 2);
        check("hold_valid", {30'd0, valid, busy}, 32'b11);
        ack_i = 1;
        tick();
        ack_i = 0;
        check("hold_ack_idle", {29'd0, inta, busy, valid}, 32'b100);
        tick();
        check("hold_restart", {30'd0, inta, busy}, 32'b01);
        int_i = 0;
        finish_seq();

        // Async reset during GAP
        int_i = 1; en_i = 1;
        tick(); tick();
        int_i = 0;
        tick();
        #2 rst_n = 1'b0;
        #1 check("rst_gap", {30'd0, inta, busy}, 32'b10);
        tick();
        rst_n = 1'b1;
        // Async reset during P2
        int_i = 1;
        tick(); tick();
        int_i = 0;
        repeat (3) tick();
        check("pre_rst_p2_low", {31'd0, inta}, 32'd0);
        #2 rst_n = 1'b0;
        #1 check("rst_p2", {30'd0, inta, busy}, 32'b10);
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (valid || busy) seen = 1'b1;
        end
        check("no_valid_after_rst", {31'd0, seen}, 32'd0);
        check("rst_vector", {24'd0, vec}, 32'h00);

        // LOW=1 / GAP=3 instance: INTA 1,0,1,1,1,0,1,1 and valid from cycle 6
        e2_inta  = 8'b1101_1101;
        e2_valid = 8'b1100_0000;
        en2 = 1;
        for (int c = 0; c < 8; c++) begin
            check($sformatf("p2_c%0d", c), {30'd0, inta2, valid2}, {30'd0, e2_inta[c], e2_valid[c]});
            if (c == 6) check("p2_vector", {23'd0, sp2, vec2}, {23'd0, 1'b0, 8'h5C});
            int2 = (c <= 1);
            data_in = (c == 5) ? 8'h5C : 8'hFF;
            tick();
        end
        ack2 = 1;
        tick();
        ack2 = 0;
        check("p2_ack", {30'd0, valid2, busy2}, 32'b00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
